// File: rtl/fr_pkg.sv
// Shared types and constants for the frame output serializer.
package fr_pkg;

    localparam int FR_N        = 32;
    localparam int FR_W        = 16;
    localparam int FR_MAX_BITS = 4096;
    localparam int FR_MAX_W    = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } fr_ser_state_t;

    // Word idx of a packed frame (word i at bits [i*w +: w]); caller truncates to w bits.
    function automatic logic [FR_MAX_W-1:0] fr_word(
        input logic [FR_MAX_BITS-1:0] frame,
        input int                     idx,
        input int                     w
    );
        logic [FR_MAX_BITS-1:0] shifted;
        shifted = frame >> (idx * w);
        return shifted[FR_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/fr_output_serializer.sv
// Parallel-to-serial output stage: loads one N-word frame, streams it word 0 first
// over valid/ready, flags the last word and records load requests it had to drop.
module fr_output_serializer
    import fr_pkg::*;
#(
    parameter int N = FR_N,
    parameter int W = FR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [N*W-1:0]      in_frame,
    output logic                in_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                overrun
);

    localparam int CW = $clog2(N + 1);

    fr_ser_state_t  state_r;
    fr_ser_state_t  state_s;
    logic [W-1:0]   word_r [N];
    logic [CW-1:0]  cnt_r;
    logic           overrun_r;
    logic           clear_s;
    logic           load_s;
    logic           accept_s;

    assign clear_s  = rst || !start;
    assign in_ready = (state_r == IDLE) && start && !rst;

    // Next-state decode and load/accept strobes.
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    load_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    accept_s = 1'b1;
                    if (cnt_r == CW'(1)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame storage: parallel load, shift toward word 0 with zero fill on accept.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            for (int i = 0; i < N; i++) begin
                word_r[i] <= {W{1'b0}};
            end
        end else if (load_s) begin
            for (int i = 0; i < N; i++) begin
                word_r[i] <= W'(fr_word(FR_MAX_BITS'(in_frame), i, W));
            end
        end else if (accept_s) begin
            for (int i = 0; i < N - 1; i++) begin
                word_r[i] <= word_r[i+1];
            end
            word_r[N-1] <= {W{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                word_r[i] <= word_r[i];
            end
        end
    end

    // Remaining-word counter; accept only happens in SHIFT where cnt >= 1.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            cnt_r <= CW'(N);
        end else if (accept_s) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky overrun: a load request seen while a frame is in flight.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            overrun_r <= 1'b0;
        end else if (in_valid && (state_r == SHIFT)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign out_data  = word_r[0];
    assign out_valid = (state_r == SHIFT);
    assign busy      = (state_r == SHIFT);
    assign out_last  = (state_r == SHIFT) && (cnt_r == CW'(1));
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_fr_output_serializer.sv
// Directed self-checking bench for fr_output_serializer (N=32, W=16).
module tb_fr_output_serializer;

    localparam int N = 32;
    localparam int W = 16;

    logic                clk;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic [N*W-1:0]      in_frame;
    logic                in_ready;
    logic signed [W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                busy;
    logic                overrun;

    int total;
    int bad;

    fr_output_serializer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_frame  (in_frame),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] wv(input int base, input int i);
        return W'(base + i);
    endfunction

    function automatic logic [N*W-1:0] mk(input int base);
        logic [N*W-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[i*W +: W] = wv(base, i);
        return f;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set before this call are sampled at the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_clear(input string tag);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chk1({tag, "_ready"}, in_ready, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_last"}, out_last, 1'b0);
        chk1({tag, "_ovr"}, overrun, 1'b0);
        chkw({tag, "_data"}, out_data, 16'h0000);
    endtask

    logic [W-1:0] expw [N];
    int           idx;
    int           cyc;

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_frame  = mk(7);
        out_ready = 1'b1;
        #1;

        // Reset with a load request pending: nothing captured.
        step();
        chk_idle_clear("rst1");
        step();
        chk_idle_clear("rst2");

        // Enable low with a load request pending.
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk_idle_clear("nostart1");
        step();
        chk_idle_clear("nostart2");

        // Basic frame -16..15 with sink always ready.
        start    = 1'b1;
        in_frame = mk(-16);
        #1;
        chk1("basic_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            chk1("basic_valid", out_valid, 1'b1);
            chk1("basic_busy", busy, 1'b1);
            chkw("basic_data", out_data, wv(-16, j));
            chk1("basic_last", out_last, (j == N - 1));
            step();
        end
        chk1("basic_post_valid", out_valid, 1'b0);
        chkw("basic_post_data", out_data, 16'h0000);
        chk1("basic_post_ready", in_ready, 1'b1);
        chk1("basic_post_ovr", overrun, 1'b0);

        // Backpressure with 0x8000 planted in word 3.
        for (int i = 0; i < N; i++) expw[i] = wv(-16, i);
        expw[3]  = 16'h8000;
        in_frame = mk(-16);
        in_frame[3*W +: W] = 16'h8000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 200) begin
            out_ready = ((cyc % 3) == 0);
            chk1("bp_valid", out_valid, 1'b1);
            chkw("bp_data", out_data, expw[idx]);
            chk1("bp_last", out_last, (idx == N - 1));
            if (out_ready) idx++;
            cyc++;
            step();
        end
        chki("bp_accepts", idx, N);
        chk1("bp_post_valid", out_valid, 1'b0);
        out_ready = 1'b1;

        // Overrun: second frame requested while word 5 is presented.
        in_frame = mk(100);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            chkw("ovr_data", out_data, wv(100, j));
            chk1("ovr_last", out_last, (j == N - 1));
            if (j == 5) begin
                in_frame = mk(500);
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            if (j == 5) chk1("ovr_set", overrun, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            chk1("ovr_no_second", out_valid, 1'b0);
            chk1("ovr_sticky", overrun, 1'b1);
            step();
        end

        // Abort after word 10 accepted, then re-enable with a fresh frame.
        in_frame = mk(1000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int j = 0; j <= 10; j++) begin
            chkw("abort_data", out_data, wv(1000, j));
            step();
        end
        chkw("abort_pre_data", out_data, wv(1000, 11));
        start = 1'b0;
        step();
        chk_idle_clear("abort");
        start    = 1'b1;
        in_frame = mk(2000);
        in_valid = 1'b1;
        #1;
        chk1("reen_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            chkw("reen_data", out_data, wv(2000, j));
            chk1("reen_last", out_last, (j == N - 1));
            step();
        end

        // Back-to-back: in_valid held high, second frame starts N+1 cycles later.
        in_frame = mk(3000);
        in_valid = 1'b1;
        step();
        for (int c = 0; c <= N; c++) begin
            if (c < N) begin
                chk1("b2b_valid", out_valid, 1'b1);
                chkw("b2b_data", out_data, wv(3000, c));
            end else begin
                chk1("b2b_gap_valid", out_valid, 1'b0);
                chk1("b2b_gap_ready", in_ready, 1'b1);
            end
            step();
        end
        in_valid = 1'b0;
        chk1("b2b_second_valid", out_valid, 1'b1);
        chkw("b2b_second_data", out_data, wv(3000, 0));
        for (int j = 1; j < N; j++) begin
            step();
            chkw("b2b_second_stream", out_data, wv(3000, j));
        end
        step();
        chk1("b2b_end_valid", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fr_output_serializer.md
# fr_output_serializer

Parallel-to-serial output stage for the 1D-CFNN datapath, mirroring the frame input buffer on the far end of the pipeline. It captures one frame of N signed W-bit results in a single load handshake and streams them out one word per accepted cycle over a valid/ready interface, flagging the final word. It sits between the last network layer and the streaming output port.

## Interface
- N, 32: words per frame; must be at least 2.
- W, 16: word width in bits; signed two's complement.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level enable; while low, the block is held in the reset state.
- in_valid  in  1  frame load request.
- in_frame  in  N*W  parallel frame; word i occupies bits [i*W +: W], and word 0 is emitted first.
- in_ready  out  1  combinational: `state==IDLE && start && !rst`.
- out_data  out  W  signed serial word, equal to buf[0].
- out_valid  out  1  word on out_data is valid.
- out_ready  in  1  sink accepts the word.
- out_last  out  1  qualifies the final word of a frame.
- busy  out  1  high in SHIFT.
- overrun  out  1  sticky: a load request arrived while the block could not accept it.

## Operation
- Storage:
  - buf[0..N-1], W bits each.
  - Remaining-word counter cnt, $clog2(N+1) bits.
  - State register: IDLE or SHIFT.
- Clear condition: `rst || !start`. It forces:
  - state=IDLE, all buf entries to 0, cnt=0, overrun=0.
  - Resulting outputs: out_data=0, out_valid=0, out_last=0, busy=0, in_ready=0.
- IDLE:
  - out_valid=0.
  - When `in_valid && in_ready`: buf[i] <= in_frame word i for all i, cnt <= N, and go to SHIFT.
- SHIFT:
  - out_valid=1 and busy=1.
  - out_last = (cnt==1).
  - On `out_ready` (accept):
    - buf[i] <= buf[i+1] for i<N-1, and buf[N-1] <= 0.
    - cnt <= cnt-1.
    - If cnt==1, go to IDLE.
  - Without out_ready, everything holds: out_data, out_valid and out_last stay stable. Sink stalls are unbounded.
- Because zeros are shifted in, out_data reads 0 whenever out_valid=0 after reset or after a completed frame.
- in_valid during SHIFT is not captured. The frame in flight is unaffected, and overrun <= 1 (when start=1).
- overrun clears only through the clear condition.
- Arithmetic:
  - No data arithmetic; words pass bit-exact, sign preserved.
  - cnt never wraps: it decrements only in SHIFT with cnt≥1.

## Timing
- Load accepted at edge k gives out_valid=1 and out_data=word 0 from cycle k+1.
- With out_ready held high, word j is presented in cycle k+1+j, and out_last is high in cycle k+N.
- After the accept of the last word, the block is in IDLE for at least one cycle with out_valid=0. In that cycle in_ready=1, so back-to-back frames cost N+1 cycles each.
- in_ready has no path from out_ready, so there is no combinational loop through the sink.
- start falling or rst mid-frame: cleared at the next edge, and the remaining words are discarded. out_valid is low the cycle after.
- Simultaneous `in_valid && in_ready && rst`: rst wins and nothing is loaded.

## Structure
- Shared package fr_pkg:
  - FR_N=32 and FR_W=16 default constants.
  - fr_ser_state_t enum {IDLE, SHIFT}.
  - Frame word-slicing helper function.
- Single module; no sub-module is natural. The shift array and counter are a handful of always blocks.

## Test plan
- Reset/enable:
  - Stimulus: assert rst, and separately hold start=0, each with in_valid=1.
  - Required: all outputs at their reset values, in_ready=0, and no capture.
- Basic frame:
  - Stimulus: start=1, load words i = i-16 (values -16..15), out_ready=1.
  - Required: out_data sequence -16..15 on consecutive cycles beginning one cycle after the load; out_last only on 15; then out_valid=0 and out_data=0.
- Backpressure:
  - Stimulus: same frame, with out_ready toggling 1,0,0,1,...
  - Required: every word is held stable while stalled; exactly 32 accepts; no duplicates or drops; sign preserved (0x8000 in, 0x8000 out).
- Overrun:
  - Stimulus: pulse in_valid with a second frame at word 5 of the first frame.
  - Required: the first frame completes unchanged, overrun=1 and stays set, and the second frame is not emitted.
- Abort:
  - Stimulus: drop start after word 10 has been accepted.
  - Required: next cycle out_valid=0, busy=0, overrun=0; on re-enable a fresh frame streams from word 0.
- Back-to-back:
  - Stimulus: in_valid held high, out_ready high, two frames.
  - Required: the second frame's first word appears exactly N+1 cycles after the first frame's first word.
